fifo_enq_arbiter: RTL and testbench
===================================

# fifo_enq_arbiter

Round-robin arbiter that shares the enqueue port of a single small FIFO between NREQ requesters. It grants one requester at a time and holds the grant for a burst of up to BURST accepted beats. It stalls on FIFO full and forwards the owner's data to the FIFO din. It sits between the producer agents and the FIFO: it drives enq/din and observes full.

## Interface
- NREQ, default 4: number of requesters, legal range 2..8.
- DW, default 1: data width per requester, matching the FIFO din width.
- BURST, default 2: maximum accepted beats per grant, at least 1.
- CLK  in  1: clock, all state updates on the rising edge.
- RST_N  in  1: reset, asynchronous, active-low.
- req  in  NREQ: per-requester request/valid; requester i holds req[i] and its data stable until a beat is accepted.
- req_data  in  NREQ*DW: requester i data in bits [i*DW +: DW].
- gnt  out  NREQ: registered one-hot grant, all-zero when idle.
- fifo_full  in  1: FIFO full flag.
- fifo_enq  out  1: FIFO enqueue strobe, combinational.
- fifo_din  out  DW: FIFO data, combinational.
- accept  out  1: beat accepted this cycle; equals fifo_enq.
- owner  out  3: registered index of the current grant owner, 0 when idle.
- xfer_cnt  out  16: total accepted beats, wraps at 2^16.

## Operation
- States: IDLE and OWN.
- IDLE:
  - If any req bit is set at an edge, choose the first set bit scanning rr_ptr, rr_ptr+1, … mod NREQ.
  - Load gnt and owner with that choice, set beat_cnt=0, go to OWN.
  - Otherwise stay in IDLE.
- OWN, per cycle:
  - fifo_enq = req[owner] & !fifo_full.
  - fifo_din = req_data slice of owner.
- OWN, transfer (fifo_enq=1):
  - xfer_cnt+1 and beat_cnt+1.
  - If beat_cnt == BURST-1, release.
- OWN, req[owner]=0 at an edge: release with no transfer.
- OWN, req[owner]=1 and fifo_full=1: stall. gnt, owner and beat_cnt hold; no timeout.
- Release: gnt=0, owner=0, rr_ptr=(released owner+1) mod NREQ, next state IDLE.
- Fairness: a requester held continuously is granted within NREQ-1 intervening grants.
- Outputs in IDLE: fifo_enq=0 and fifo_din=0.
- beat_cnt is clog2(BURST)+1 bits. rr_ptr is clog2(NREQ) bits; wrap is an explicit compare to NREQ-1 so non-power-of-2 NREQ is correct.
- req bits of non-owners are ignored during OWN; they are sampled only in IDLE.

## Timing
- Reset, asynchronous, effective mid-burst:
  - state=IDLE, gnt=0, owner=0, rr_ptr=0, beat_cnt=0, xfer_cnt=0.
  - Combinationally this also gives fifo_enq=0, accept=0, fifo_din=0.
  - A beat in flight at reset assertion is not counted.
- Grant latency:
  - req[i] first sampled at edge k in IDLE → gnt[i] high after edge k.
  - First transfer is the cycle between edges k and k+1, counted at edge k+1.
- Burst of BURST beats with no stall: BURST consecutive accept cycles, gnt drops after the last one, then 1 idle cycle before the next grant.
- Per-burst throughput: BURST beats in BURST+1 cycles.
- fifo_full asserted in the same cycle as req[owner]: no enq that cycle, no counter change.
- fifo_full deasserting releases the stall in the same cycle.
- Dropping req[owner] while stalled on full: release at that edge, no transfer, rr_ptr advances.
- Simultaneous requests at reset exit: requester 0 wins first (rr_ptr=0).
- xfer_cnt wraps from 0xFFFF to 0x0000 on the next accept.

## Test plan
- Reset then req=4'b0001, NREQ=4, BURST=2, full=0:
  - gnt=0001 one cycle later.
  - Two accept cycles with fifo_din = req_data[0] slice.
  - gnt returns to 0; xfer_cnt=2; owner=0; next rr_ptr=1.
- req=4'b1111 held continuously, full=0:
  - Grant order 0,1,2,3,0 with an idle cycle between bursts.
  - Each burst is exactly 2 beats; xfer_cnt=10 after 5 grants.
- Owner granted, fifo_full=1 for 5 cycles:
  - fifo_enq=0 throughout; gnt held; beat_cnt and xfer_cnt unchanged.
  - Transfer occurs in the first cycle full=0.
- Owner 2 drops req after 1 beat with BURST=2: release after that edge, xfer_cnt+1 only, next grant goes to the lowest pending index ≥3 (wrapping).
- RST_N asserted mid-burst while owner 1 is accepting:
  - All outputs clear immediately (gnt=0, owner=0, fifo_enq=0, xfer_cnt=0).
  - After release of reset with req=4'b1010, requester 1 wins (rr_ptr=0).
- xfer_cnt preloaded near wrap by running 65535 beats, then 2 more beats: xfer_cnt reads 0xFFFF then 0x0000, then 0x0001.

Source files
------------

// File: rtl/fifo_enq_arbiter.sv
// fifo_enq_arbiter
//   Round-robin arbiter sharing the enqueue port of one FIFO between NREQ
//   requesters. A grant is held for up to BURST accepted beats. The grant
//   also ends early when the owner drops its request. While the FIFO is
//   full the grant stalls with no timeout. The owner's data is forwarded
//   to the FIFO din.
//
// Parameters
//   NREQ   number of requesters (2..8)
//   DW     data width per requester
//   BURST  maximum accepted beats per grant (>= 1)
//
// Ports
//   CLK        clock, rising edge
//   RST_N      asynchronous active-low reset
//   req        per-requester request/valid
//   req_data   requester i data in [i*DW +: DW]
//   gnt        registered one-hot grant, zero when idle
//   fifo_full  FIFO full flag
//   fifo_enq   FIFO enqueue strobe (combinational)
//   fifo_din   FIFO data (combinational, zero when idle)
//   accept     beat accepted this cycle (same as fifo_enq)
//   owner      registered index of the grant owner, 0 when idle
//   xfer_cnt   total accepted beats, wraps at 2^16
module fifo_enq_arbiter #(
  parameter int NREQ  = 4,
  parameter int DW    = 1,
  parameter int BURST = 2
) (
  input  logic               CLK,
  input  logic               RST_N,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ*DW-1:0] req_data,
  output logic [NREQ-1:0]    gnt,
  input  logic               fifo_full,
  output logic               fifo_enq,
  output logic [DW-1:0]      fifo_din,
  output logic               accept,
  output logic [2:0]         owner,
  output logic [15:0]        xfer_cnt
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int BW = $clog2(BURST) + 1;

  typedef enum logic {IDLE, OWN} state_t;

  state_t            state_reg, state_next;
  logic [NREQ-1:0]   gnt_reg, gnt_next;
  logic [2:0]        owner_reg, owner_next;
  logic [PW-1:0]     rr_ptr_reg, rr_ptr_next;
  logic [BW-1:0]     beat_cnt_reg, beat_cnt_next;
  logic [15:0]       xfer_cnt_reg;

  logic              owner_req;
  logic [NREQ-1:0]   rot_req;
  logic              any_req;
  logic [PW-1:0]     rot_off;
  logic [PW:0]       pick_sum;
  logic [PW:0]       pick_idx;
  logic [DW-1:0]     din_slice [NREQ];
  logic [DW-1:0]     din_acc;

  // gnt_reg is one-hot while owning, so masking with it selects the
  // owner's request and data without a variable-width index.
  assign owner_req = |(req & gnt_reg);
  assign fifo_enq  = (state_reg == OWN) && owner_req && !fifo_full;
  assign accept    = fifo_enq;

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_din
    assign din_slice[gi] = gnt_reg[gi] ? req_data[gi*DW +: DW] : '0;
  end

  always_comb begin
    din_acc = '0;
    for (int i = 0; i < NREQ; i++) begin
      din_acc = din_acc | din_slice[i];
    end
  end
  assign fifo_din = din_acc;

  // Rotate the request vector so bit 0 corresponds to rr_ptr; the lowest
  // set bit of the rotated vector is the round-robin winner's offset.
  always_comb begin
    rot_req = NREQ'({req, req} >> rr_ptr_reg);
    any_req = 1'b0;
    rot_off = '0;
    for (int j = NREQ - 1; j >= 0; j--) begin
      if (rot_req[j]) begin
        any_req = 1'b1;
        rot_off = PW'(j);
      end
    end
  end

  // Explicit modulo so non-power-of-2 NREQ wraps correctly.
  assign pick_sum = {1'b0, rr_ptr_reg} + {1'b0, rot_off};
  assign pick_idx = (pick_sum > (PW+1)'(NREQ - 1)) ? pick_sum - (PW+1)'(NREQ)
                                                   : pick_sum;

  always_comb begin
    state_next    = state_reg;
    gnt_next      = gnt_reg;
    owner_next    = owner_reg;
    rr_ptr_next   = rr_ptr_reg;
    beat_cnt_next = beat_cnt_reg;
    unique case (state_reg)
      IDLE: begin
        if (any_req) begin
          state_next    = OWN;
          gnt_next      = NREQ'(1) << pick_idx;
          owner_next    = 3'(pick_idx);
          beat_cnt_next = '0;
        end
      end
      OWN: begin
        if (!owner_req || (fifo_enq && beat_cnt_reg == BW'(BURST - 1))) begin
          // Release: request withdrawn or burst complete.
          state_next    = IDLE;
          gnt_next      = '0;
          owner_next    = '0;
          beat_cnt_next = '0;
          rr_ptr_next   = (owner_reg == 3'(NREQ - 1)) ? '0
                                                      : owner_reg[PW-1:0] + PW'(1);
        end else if (fifo_enq) begin
          beat_cnt_next = beat_cnt_reg + BW'(1);
        end
        // Otherwise stalled on full: everything holds.
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_reg    <= IDLE;
      gnt_reg      <= '0;
      owner_reg    <= '0;
      rr_ptr_reg   <= '0;
      beat_cnt_reg <= '0;
      xfer_cnt_reg <= '0;
    end else begin
      state_reg    <= state_next;
      gnt_reg      <= gnt_next;
      owner_reg    <= owner_next;
      rr_ptr_reg   <= rr_ptr_next;
      beat_cnt_reg <= beat_cnt_next;
      if (fifo_enq) begin
        xfer_cnt_reg <= xfer_cnt_reg + 16'd1;
      end
    end
  end

  assign gnt      = gnt_reg;
  assign owner    = owner_reg;
  assign xfer_cnt = xfer_cnt_reg;

endmodule

// File: tb/tb_fifo_enq_arbiter.sv
// Testbench for fifo_enq_arbiter: a per-cycle vector table for the main
// arbitration behaviour, hand sequences for asynchronous reset mid-burst,
// and a second instance that runs the transfer counter through its wrap.
module tb_fifo_enq_arbiter;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic [3:0]  gnt;
  logic        fifo_full;
  logic        fifo_enq;
  logic [7:0]  fifo_din;
  logic        accept;
  logic [2:0]  owner;
  logic [15:0] xfer_cnt;

  // Wrap-test instance: 3 requesters, long bursts to reach 65535 beats fast.
  logic        w_rst_n;
  logic [2:0]  w_req;
  logic [2:0]  w_data;
  logic [2:0]  w_gnt;
  logic        w_full;
  logic        w_enq;
  logic [0:0]  w_din;
  logic        w_accept;
  logic [2:0]  w_owner;
  logic [15:0] w_xfer;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  fifo_enq_arbiter #(.NREQ(4), .DW(8), .BURST(2)) dut (
    .CLK(CLK), .RST_N(RST_N), .req(req), .req_data(req_data), .gnt(gnt),
    .fifo_full(fifo_full), .fifo_enq(fifo_enq), .fifo_din(fifo_din),
    .accept(accept), .owner(owner), .xfer_cnt(xfer_cnt)
  );

  fifo_enq_arbiter #(.NREQ(3), .DW(1), .BURST(255)) u_wrap (
    .CLK(CLK), .RST_N(w_rst_n), .req(w_req), .req_data(w_data), .gnt(w_gnt),
    .fifo_full(w_full), .fifo_enq(w_enq), .fifo_din(w_din),
    .accept(w_accept), .owner(w_owner), .xfer_cnt(w_xfer)
  );

  typedef struct {
    logic [3:0]  req;
    logic        full;
    logic [3:0]  gnt;
    logic [2:0]  owner;
    logic        enq;
    logic [7:0]  din;
    logic [15:0] xfer;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic [3:0] r, input logic f, input logic [3:0] g,
                     input logic [2:0] o, input logic e, input logic [7:0] d,
                     input logic [15:0] x);
    vec_t v;
    v.req = r; v.full = f; v.gnt = g; v.owner = o; v.enq = e; v.din = d; v.xfer = x;
    vecs.push_back(v);
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [3:0] g, input logic [2:0] o,
                           input logic e, input logic [7:0] d, input logic [15:0] x);
    check({tag, " gnt"}, 32'(gnt), 32'(g));
    check({tag, " owner"}, 32'(owner), 32'(o));
    check({tag, " fifo_enq"}, 32'(fifo_enq), 32'(e));
    check({tag, " accept"}, 32'(accept), 32'(e));
    check({tag, " fifo_din"}, 32'(fifo_din), 32'(d));
    check({tag, " xfer_cnt"}, 32'(xfer_cnt), 32'(x));
  endtask

  initial begin
    int wcnt;
    int cyc;
    RST_N     = 1'b0;
    w_rst_n   = 1'b0;
    req       = '0;
    req_data  = 32'h44332211;
    fifo_full = 1'b0;
    w_req     = 3'b111;
    w_data    = 3'b101;
    w_full    = 1'b0;

    //  req    full gnt   own  enq din    xfer
    // Single requester 0, one burst of two beats.
    add(4'h1, 0, 4'h0, 0, 0, 8'h00, 0);
    add(4'h1, 0, 4'h1, 0, 1, 8'h11, 0);
    add(4'h1, 0, 4'h1, 0, 1, 8'h11, 1);
    add(4'h0, 0, 4'h0, 0, 0, 8'h00, 2);
    // All requesting: order 1,2,3,0 with an idle cycle between bursts.
    add(4'hF, 0, 4'h0, 0, 0, 8'h00, 2);
    add(4'hF, 0, 4'h2, 1, 1, 8'h22, 2);
    add(4'hF, 0, 4'h2, 1, 1, 8'h22, 3);
    add(4'hF, 0, 4'h0, 0, 0, 8'h00, 4);
    add(4'hF, 0, 4'h4, 2, 1, 8'h33, 4);
    add(4'hF, 0, 4'h4, 2, 1, 8'h33, 5);
    add(4'hF, 0, 4'h0, 0, 0, 8'h00, 6);
    add(4'hF, 0, 4'h8, 3, 1, 8'h44, 6);
    add(4'hF, 0, 4'h8, 3, 1, 8'h44, 7);
    add(4'hF, 0, 4'h0, 0, 0, 8'h00, 8);
    add(4'hF, 0, 4'h1, 0, 1, 8'h11, 8);
    add(4'hF, 0, 4'h1, 0, 1, 8'h11, 9);
    // Requester 1 stalled by full for five cycles, then a full burst.
    add(4'h2, 0, 4'h0, 0, 0, 8'h00, 10);
    for (int i = 0; i < 5; i++) add(4'h2, 1, 4'h2, 1, 0, 8'h22, 10);
    add(4'h2, 0, 4'h2, 1, 1, 8'h22, 10);
    add(4'h2, 0, 4'h2, 1, 1, 8'h22, 11);
    // Owner 2 drops after one beat; next grant wraps past 3 to 0.
    add(4'h5, 0, 4'h0, 0, 0, 8'h00, 12);
    add(4'h5, 0, 4'h4, 2, 1, 8'h33, 12);
    add(4'h1, 0, 4'h4, 2, 0, 8'h33, 13);
    add(4'h1, 0, 4'h0, 0, 0, 8'h00, 13);
    add(4'h1, 0, 4'h1, 0, 1, 8'h11, 13);
    add(4'h1, 0, 4'h1, 0, 1, 8'h11, 14);
    // Owner 3 drops while stalled: release, rr_ptr wraps to 0.
    add(4'h8, 0, 4'h0, 0, 0, 8'h00, 15);
    add(4'h8, 1, 4'h8, 3, 0, 8'h44, 15);
    add(4'h0, 1, 4'h8, 3, 0, 8'h44, 15);
    add(4'h9, 0, 4'h0, 0, 0, 8'h00, 15);
    add(4'h9, 0, 4'h1, 0, 1, 8'h11, 15);

    repeat (3) @(negedge CLK);
    check_all("reset", 4'h0, 3'd0, 1'b0, 8'h00, 16'd0);
    RST_N = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      req       = vecs[i].req;
      fifo_full = vecs[i].full;
      #1;
      $display("vec %0d: req=%b full=%b gnt=%b owner=%0d enq=%b din=%h xfer=%0d",
               i, req, fifo_full, gnt, owner, fifo_enq, fifo_din, xfer_cnt);
      check_all($sformatf("vec%0d", i), vecs[i].gnt, vecs[i].owner, vecs[i].enq,
                vecs[i].din, vecs[i].xfer);
      @(negedge CLK);
    end

    // Owner 0 drops req: release, rr_ptr=1. Then requester 1 starts a burst.
    req = 4'h0;
    @(negedge CLK);
    req = 4'h2;
    @(negedge CLK);
    #1;
    $display("pre-reset: gnt=%b enq=%b xfer=%0d", gnt, fifo_enq, xfer_cnt);
    check_all("preRst", 4'h2, 3'd1, 1'b1, 8'h22, 16'd16);
    #1 RST_N = 1'b0;
    #1;
    $display("async reset: gnt=%b owner=%0d enq=%b xfer=%0d", gnt, owner, fifo_enq, xfer_cnt);
    check_all("asyncRst", 4'h0, 3'd0, 1'b0, 8'h00, 16'd0);
    @(negedge CLK);
    req   = 4'hA;
    RST_N = 1'b1;
    @(negedge CLK);
    #1;
    $display("post-reset: req=%b gnt=%b owner=%0d", req, gnt, owner);
    check_all("postRst", 4'h2, 3'd1, 1'b1, 8'h22, 16'd0);
    req = 4'h0;

    // Counter wrap on the second instance.
    @(negedge CLK);
    w_rst_n = 1'b1;
    wcnt = 0;
    cyc  = 0;
    while (wcnt < 65535 && cyc < 70000) begin
      @(negedge CLK);
      cyc++;
      if (w_accept) wcnt++;
    end
    check("wrap budget", 32'(cyc < 70000), 32'd1);
    @(negedge CLK);
    $display("wrap: xfer=%h", w_xfer);
    check("wrap FFFF", 32'(w_xfer), 32'h0000FFFF);
    cyc = 0;
    while (!w_accept && cyc < 1000) begin @(negedge CLK); cyc++; end
    @(negedge CLK);
    $display("wrap: xfer=%h", w_xfer);
    check("wrap 0000", 32'(w_xfer), 32'h00000000);
    cyc = 0;
    while (!w_accept && cyc < 1000) begin @(negedge CLK); cyc++; end
    @(negedge CLK);
    $display("wrap: xfer=%h", w_xfer);
    check("wrap 0001", 32'(w_xfer), 32'h00000001);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
